iir_filter_mac: RTL and testbench

- Parametrised direct-form-I IIR filter. Generalises the fixed 2-tap deemphasis filter to TAPS taps, a configurable fixed-point format and run-time coefficients.
- Reads one sample from a FWFT input FIFO and computes one output sample over multiple cycles, using one x-multiplier and one y-multiplier.
- Writes the output sample to an output FIFO.
- Sits in the FM demod chain after the demodulator (deemphasis) and is reusable for other audio IIR stages.

---
 rtl/iir_filter_mac_if.sv | 33 +++
 rtl/iir_filter_mac.sv | 172 +++++++++++++++++
 tb/tb_iir_filter_mac.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_filter_mac_if.sv
// iir_filter_mac_if: FIFO-side signals of the IIR filter.
// The master modport is the filter itself (it pops the input FIFO and pushes
// the output FIFO); the slave modport is the FIFO / environment side.
interface iir_filter_mac_if #(
  parameter int DATA_WIDTH = 32
);
  // Input FIFO (first-word fall-through).
  logic [DATA_WIDTH-1:0] x_in;
  logic                  x_in_empty;
  logic                  x_in_rd_en;
  // Output FIFO.
  logic [DATA_WIDTH-1:0] y_out;
  logic                  y_out_full;
  logic                  y_out_wr_en;

  modport master (
    input  x_in,
    input  x_in_empty,
    output x_in_rd_en,
    output y_out,
    input  y_out_full,
    output y_out_wr_en
  );

  modport slave (
    output x_in,
    output x_in_empty,
    input  x_in_rd_en,
    input  y_out,
    output y_out_full,
    input  y_out_wr_en
  );
endinterface

// File: rtl/iir_filter_mac.sv
// iir_filter_mac: direct-form-I IIR filter, TAPS feed-forward taps and
// TAPS-1 feedback taps, one sample per TAPS+2 cycles using a single
// x-multiplier and a single y-multiplier stepped over the taps.
// Optional build macro IIR_FILTER_SATURATE_EN: clamp the reduced result to the
// DATA_WIDTH signed range instead of wrapping (the clamped value is also the
// one fed back into the y history).
module iir_filter_mac #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 2,
  parameter int FRAC_BITS  = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [TAPS*DATA_WIDTH-1:0] x_coeffs,
  input  logic [TAPS*DATA_WIDTH-1:0] y_coeffs,
  iir_filter_mac_if.master           bus
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  // Sized from the full product width so that even a shifted product larger
  // than DATA_WIDTH (e.g. a saturating case) cannot wrap inside the sum.
  localparam int ACC_W  = PROD_W + $clog2(2 * TAPS) + 1;
  localparam int KW     = $clog2(TAPS);
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

`ifdef IIR_FILTER_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WRITE
  } state_t;

  state_t                        r_state;
  logic signed [DATA_WIDTH-1:0]  r_x_hist [TAPS];
  // Index 0 is never loaded; it stays zero and is masked out at k = 0.
  logic signed [DATA_WIDTH-1:0]  r_y_hist [TAPS];
  logic signed [ACC_W-1:0]       r_acc;
  logic [KW-1:0]                 r_k;
  logic [DATA_WIDTH-1:0]         r_y_out;

  logic signed [DATA_WIDTH-1:0]  w_b_arr [TAPS];
  logic signed [DATA_WIDTH-1:0]  w_a_arr [TAPS];
  logic signed [DATA_WIDTH-1:0]  w_b;
  logic signed [DATA_WIDTH-1:0]  w_a;
  logic signed [DATA_WIDTH-1:0]  w_xh;
  logic signed [DATA_WIDTH-1:0]  w_yh;
  logic signed [PROD_W-1:0]      w_prod_x;
  logic signed [PROD_W-1:0]      w_prod_y;
  logic signed [PROD_W-1:0]      w_sh_x;
  logic signed [PROD_W-1:0]      w_sh_y;
  logic signed [ACC_W-1:0]       w_term_x;
  logic signed [ACC_W-1:0]       w_term_y;
  logic signed [ACC_W-1:0]       w_sum;
  logic [DATA_WIDTH-1:0]         w_result;
  logic                          w_rd_en;
  logic                          w_wr_en;

  // Unpack the coefficient buses into per-tap arrays.
  always_comb begin
    for (int unsigned i = 0; i < TAPS; i++) begin
      w_b_arr[i] = x_coeffs[i*DATA_WIDTH +: DATA_WIDTH];
      w_a_arr[i] = y_coeffs[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // One MAC step: both products for tap k, floor-shifted and summed into acc.
  always_comb begin
    w_b      = w_b_arr[r_k];
    w_a      = w_a_arr[r_k];
    w_xh     = r_x_hist[r_k];
    w_yh     = r_y_hist[r_k];
    w_prod_x = w_b * w_xh;
    w_prod_y = w_a * w_yh;
    w_sh_x   = w_prod_x >>> FRAC_BITS;
    w_sh_y   = w_prod_y >>> FRAC_BITS;
    w_term_x = {{(ACC_W-PROD_W){w_sh_x[PROD_W-1]}}, w_sh_x};
    w_term_y = '0;
    if (r_k != '0) begin
      w_term_y = {{(ACC_W-PROD_W){w_sh_y[PROD_W-1]}}, w_sh_y};
    end
    w_sum = r_acc + w_term_x + w_term_y;
  end

  // Reduce the final accumulator value to the output width.
  always_comb begin
`ifdef IIR_FILTER_SATURATE_EN
    if (w_sum > SAT_MAX) begin
      w_result = SAT_MAX[DATA_WIDTH-1:0];
    end else if (w_sum < SAT_MIN) begin
      w_result = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      w_result = w_sum[DATA_WIDTH-1:0];
    end
`else
    w_result = w_sum[DATA_WIDTH-1:0];
`endif
  end

  // FIFO strobes: combinational from state and FIFO flags, suppressed by flush.
  always_comb begin
    w_rd_en = (r_state == S_IDLE) && !bus.x_in_empty && !flush && !rst;
    w_wr_en = (r_state == S_WRITE) && !bus.y_out_full && !flush;
  end

  assign bus.x_in_rd_en  = w_rd_en;
  assign bus.y_out_wr_en = w_wr_en;
  assign bus.y_out       = r_y_out;

  // Sequencer: IDLE (read) -> MAC (TAPS steps) -> WRITE, with flush override.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_k     <= '0;
      r_y_out <= '0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        r_x_hist[i] <= '0;
        r_y_hist[i] <= '0;
      end
    end else if (flush) begin
      // History cleared, in-flight sample dropped; y_out deliberately kept.
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_k     <= '0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        r_x_hist[i] <= '0;
        r_y_hist[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rd_en) begin
            for (int unsigned i = 1; i < TAPS; i++) begin
              r_x_hist[i] <= r_x_hist[i-1];
            end
            r_x_hist[0] <= bus.x_in;
            r_acc       <= '0;
            r_k         <= '0;
            r_state     <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          if (r_k == K_LAST) begin
            r_y_out <= w_result;
            r_state <= S_WRITE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_WRITE: begin
          if (w_wr_en) begin
            for (int unsigned i = 2; i < TAPS; i++) begin
              r_y_hist[i] <= r_y_hist[i-1];
            end
            r_y_hist[1] <= r_y_out;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_filter_mac.sv
// tb_iir_filter_mac: directed checks of iir_filter_mac with hand-computed
// expected values. Three instances: TAPS=2/32-bit (impulse, flush,
// backpressure, reset), TAPS=4/32-bit (throughput), TAPS=2/16-bit (overflow).
module tb_iir_filter_mac;

  logic clk;
  logic rst;
  logic flush2, flush4, flush16;

  int n_asserts;
  int n_fail;

  iir_filter_mac_if #(.DATA_WIDTH(32)) if2 ();
  iir_filter_mac_if #(.DATA_WIDTH(32)) if4 ();
  iir_filter_mac_if #(.DATA_WIDTH(16)) if16 ();

  logic [63:0]  xc2, yc2;
  logic [127:0] xc4, yc4;
  logic [31:0]  xc16, yc16;

  assign xc2  = {32'd178, 32'd178};
  assign yc2  = {32'hFFFFFD66, 32'd0};
  assign xc4  = {32'd0, 32'd0, 32'd0, 32'd1024};
  assign yc4  = '0;
  assign xc16 = {16'd0, 16'd32767};
  assign yc16 = '0;

  iir_filter_mac #(.DATA_WIDTH(32), .TAPS(2), .FRAC_BITS(10)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush2),
    .x_coeffs(xc2), .y_coeffs(yc2), .bus(if2)
  );

  iir_filter_mac #(.DATA_WIDTH(32), .TAPS(4), .FRAC_BITS(10)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush4),
    .x_coeffs(xc4), .y_coeffs(yc4), .bus(if4)
  );

  iir_filter_mac #(.DATA_WIDTH(16), .TAPS(2), .FRAC_BITS(10)) u_dut16 (
    .clk(clk), .rst(rst), .flush(flush16),
    .x_coeffs(xc16), .y_coeffs(yc16), .bus(if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push one sample into the TAPS=2 32-bit instance and check its result.
  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic do_sample2(input logic [31:0] x, input logic [31:0] exp, input string tag);
    logic got;
    if2.x_in = x;
    if2.x_in_empty = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (if2.x_in_rd_en) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_rd"}, got, 1);
    @(posedge clk); #1;
    if2.x_in_empty = 1'b1;
    @(negedge clk);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (if2.y_out_wr_en) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_wr"}, got, 1);
    chk(tag, if2.y_out, exp);
    @(negedge clk);
  endtask

  // Same for the 16-bit instance.
  task automatic do_sample16(input logic [15:0] x, input logic [15:0] exp, input string tag);
    logic got;
    if16.x_in = x;
    if16.x_in_empty = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (if16.x_in_rd_en) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_rd"}, got, 1);
    @(posedge clk); #1;
    if16.x_in_empty = 1'b1;
    @(negedge clk);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (if16.y_out_wr_en) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_wr"}, got, 1);
    chk(tag, if16.y_out, exp);
    @(negedge clk);
  endtask

  initial begin
    logic        rd_seen;
    logic        got;
    logic [15:0] exp_pos, exp_neg;

    n_asserts = 0;
    n_fail    = 0;

`ifdef IIR_FILTER_SATURATE_EN
    exp_pos = 16'h7FFF;
    exp_neg = 16'h8000;
`else
    exp_pos = 16'hFFC0;
    exp_neg = 16'h0020;
`endif

    rst = 1'b1;
    flush2 = 1'b0; flush4 = 1'b0; flush16 = 1'b0;
    if2.x_in = '0;  if2.x_in_empty = 1'b0;  if2.y_out_full = 1'b0;
    if4.x_in = '0;  if4.x_in_empty = 1'b1;  if4.y_out_full = 1'b0;
    if16.x_in = '0; if16.x_in_empty = 1'b1; if16.y_out_full = 1'b0;

    // Reset state (if2 has data available: read strobe must still be low).
    repeat (3) @(negedge clk);
    #1;
    chk("rst_y2",   if2.y_out, 0);
    chk("rst_rd2",  if2.x_in_rd_en, 0);
    chk("rst_wr2",  if2.y_out_wr_en, 0);
    chk("rst_y4",   if4.y_out, 0);
    chk("rst_wr4",  if4.y_out_wr_en, 0);
    chk("rst_y16",  if16.y_out, 0);
    chk("rst_wr16", if16.y_out_wr_en, 0);
    if2.x_in_empty = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Throughput, TAPS=4, identity b0: read every 6 cycles, write 5 after.
    if4.x_in = 32'd100;
    if4.x_in_empty = 1'b0;
    for (int cyc = 0; cyc < 18; cyc++) begin
      #1;
      chk("tp_rd", if4.x_in_rd_en, ((cyc % 6) == 0));
      chk("tp_wr", if4.y_out_wr_en, ((cyc % 6) == 5));
      if ((cyc % 6) == 5) chk("tp_y", if4.y_out, 64'(100 + cyc / 6));
      rd_seen = if4.x_in_rd_en;
      @(posedge clk); #1;
      if (rd_seen) if4.x_in = if4.x_in + 32'd1;
      @(negedge clk);
    end
    if4.x_in_empty = 1'b1;
    repeat (8) @(negedge clk);

    // Impulse response.
    do_sample2(32'd1024, 32'd178,       "imp0");
    do_sample2(32'd0,    32'd62,        "imp1");
    do_sample2(32'd0,    32'hFFFFFFD7,  "imp2");

    // Flush during MAC, then flush while data is waiting in IDLE.
    if2.x_in = 32'd1024;
    if2.x_in_empty = 1'b0;
    #1;
    chk("fl_rd", if2.x_in_rd_en, 1);
    @(posedge clk); #1;
    if2.x_in = 32'd0;
    flush2 = 1'b1;
    @(negedge clk); #1;
    chk("fl_mac_rd", if2.x_in_rd_en, 0);
    chk("fl_mac_wr", if2.y_out_wr_en, 0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("fl_noread", if2.x_in_rd_en, 0);
    chk("fl_yhold",  if2.y_out, 32'hFFFFFFD7);
    @(posedge clk); #1;
    flush2 = 1'b0;
    if2.x_in_empty = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("fl_nowr", if2.y_out_wr_en, 0);
    end
    @(negedge clk);
    do_sample2(32'd0, 32'd0, "fl_next");

    // Backpressure: output full for >20 cycles in WRITE.
    if2.y_out_full = 1'b1;
    if2.x_in = 32'd1024;
    if2.x_in_empty = 1'b0;
    #1;
    chk("bp_rd", if2.x_in_rd_en, 1);
    @(posedge clk); #1;
    if2.x_in = 32'd0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk); #1;
      chk("bp_nowr", if2.y_out_wr_en, 0);
      chk("bp_nord", if2.x_in_rd_en, 0);
      if (i >= 2) chk("bp_hold", if2.y_out, 32'd178);
    end
    if2.y_out_full = 1'b0;
    #1;
    chk("bp_wr",  if2.y_out_wr_en, 1);
    chk("bp_val", if2.y_out, 32'd178);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("bp_next_rd", if2.x_in_rd_en, 1);
    chk("bp_one_wr",  if2.y_out_wr_en, 0);
    @(posedge clk); #1;
    if2.x_in_empty = 1'b1;
    @(negedge clk);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (if2.y_out_wr_en) got = 1'b1;
      else @(negedge clk);
    end
    chk("bp_next_wr", got, 1);
    chk("bp_next",    if2.y_out, 32'd62);
    @(negedge clk);

    // Overflow on the 16-bit instance.
    do_sample16(16'h7FFF, exp_pos, "ovf_pos");
    do_sample16(16'h8000, exp_neg, "ovf_neg");

    // Asynchronous reset in the middle of MAC.
    if2.x_in = 32'd1024;
    if2.x_in_empty = 1'b0;
    #1;
    chk("ar_rd", if2.x_in_rd_en, 1);
    @(posedge clk); #1;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_y2",  if2.y_out, 0);
    chk("ar_rd2", if2.x_in_rd_en, 0);
    chk("ar_wr2", if2.y_out_wr_en, 0);
    chk("ar_y4",  if4.y_out, 0);
    chk("ar_y16", if16.y_out, 0);
    if2.x_in_empty = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_sample2(32'd1024, 32'd178, "ar_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
